// File: rtl/rtp_engine_rx_pkg.sv
// Shared RTP engine receive-side definitions.
// Holds the receive FSM state encoding, RTP constants, packed structs for
// pulling fields out of header beats, and a byte-enable popcount helper.
package rtp_engine_rx_pkg;

    localparam logic [1:0] RTP_VERSION   = 2'd2;
    localparam int         RTP_HDR_BEATS = 5;

    typedef enum logic [2:0] {
        IDLE_RECV      = 3'd0,
        HEADER_RECV    = 3'd1,
        PD_HEADER_RECV = 3'd2,
        PAYLOAD_RECV   = 3'd3,
        DROP_RECV      = 3'd4
    } state_rtp_recv;

    // First RTP header word (beat 0), network bit order.
    typedef struct packed {
        logic [1:0]  version;
        logic        padding;
        logic        extension;
        logic [3:0]  csrc_count;
        logic        marker;
        logic [6:0]  payload_type;
        logic [15:0] sequence_nr;
    } rtp_hdr_w0_t;

    // RFC 4175 payload header with a single line segment (beats 3 and 4).
    typedef struct packed {
        logic [15:0] ext_seq_num;
        logic [15:0] length;
        logic        field;
        logic [14:0] line_num;
        logic        continuation;
        logic [14:0] offset;
    } rtp_pd_hdr_t;

    // Number of valid bytes in a 4-bit tkeep.
    function automatic logic [2:0] popcount4(input logic [3:0] bits);
        return {2'd0, bits[0]} + {2'd0, bits[1]} + {2'd0, bits[2]} + {2'd0, bits[3]};
    endfunction

endpackage

// File: rtl/rtp_engine_rx_seq_check.sv
// Extended RTP sequence continuity tracker.
// Ports: aclk/aresetn clock and async active-low reset; chk strobes one
// validated packet whose 32-bit extended sequence is ext_seq; seq_err pulses
// for one cycle on a discontinuity; seq_err_count saturates at 0xFFFF.
module rtp_engine_rx_seq_check (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        chk,
    input  logic [31:0] ext_seq,
    output logic        seq_err,
    output logic [15:0] seq_err_count
);

    logic [31:0] expected_r;
    logic        first_r;
    logic        seq_err_r;
    logic [15:0] seq_err_count_r;

    // Track the next expected sequence; the first packet after reset only seeds it.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            expected_r      <= 32'd0;
            first_r         <= 1'b1;
            seq_err_r       <= 1'b0;
            seq_err_count_r <= 16'd0;
        end else begin
            seq_err_r <= 1'b0;
            if (chk) begin
                expected_r <= ext_seq + 32'd1;
                first_r    <= 1'b0;
                if (!first_r && (ext_seq != expected_r)) begin
                    seq_err_r <= 1'b1;
                    if (seq_err_count_r != 16'hFFFF) begin
                        seq_err_count_r <= seq_err_count_r + 16'd1;
                    end else begin
                        seq_err_count_r <= seq_err_count_r;
                    end
                end else begin
                    seq_err_count_r <= seq_err_count_r;
                end
            end else begin
                expected_r <= expected_r;
            end
        end
    end

    assign seq_err       = seq_err_r;
    assign seq_err_count = seq_err_count_r;

endmodule

// File: rtl/rtp_engine_rx.sv
// Receive-side RTP depacketizer (RFC 4175 style, one line segment per packet).
// Ports: aclk/aresetn; cfg_ssrc expected SSRC; s_axis_* UDP payload input;
// m_axis_* pixel payload output (tuser = SOF) with m_line_num/m_offset/m_field
// sideband; seq_err/len_err one-cycle error pulses; pkt_count, drop_count and
// seq_err_count saturating statistics.
module rtp_engine_rx
    import rtp_engine_rx_pkg::*;
#(
    parameter logic [6:0] PAYLOAD_TYPE = 7'd96,
    parameter bit         SSRC_CHECK   = 1'b0
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [31:0] cfg_ssrc,
    input  logic [31:0] s_axis_tdata,
    input  logic [3:0]  s_axis_tkeep,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        s_axis_tlast,
    output logic [31:0] m_axis_tdata,
    output logic [3:0]  m_axis_tkeep,
    output logic        m_axis_tuser,
    output logic        m_axis_tlast,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic [14:0] m_line_num,
    output logic [14:0] m_offset,
    output logic        m_field,
    output logic        seq_err,
    output logic        len_err,
    output logic [31:0] pkt_count,
    output logic [15:0] drop_count,
    output logic [15:0] seq_err_count
);

    state_rtp_recv state_r, state_next_s;
    logic [2:0]    beat_r;
    rtp_hdr_w0_t   hdr0_r;
    logic [31:0]   ssrc_r, cfg_ssrc_r, pd_hi_r;
    rtp_pd_hdr_t   pd_s;
    logic          in_fire_s, last_hdr_beat_s, hdr_ok_s, ssrc_ok_s;
    logic          drop_s, hdr_pass_s, zero_len_s, pay_last_s;
    logic [31:0]   out_data_r;
    logic [3:0]    out_keep_r;
    logic          out_user_r, out_last_r, out_valid_r, sof_r;
    logic [14:0]   line_r, offset_r;
    logic          field_r, len_err_r, len_uf_r;
    logic [15:0]   len_cnt_r, drop_count_r;
    logic [31:0]   pkt_count_r;
    logic [2:0]    pop_s;
    logic [16:0]   len_diff_s;

    assign in_fire_s       = s_axis_tvalid & s_axis_tready;
    assign last_hdr_beat_s = (beat_r == 3'(RTP_HDR_BEATS - 1));
    // Beat 4 is validated in the cycle it arrives, so combine it live with beat 3.
    assign pd_s            = rtp_pd_hdr_t'({pd_hi_r, s_axis_tdata});
    assign ssrc_ok_s       = (SSRC_CHECK == 1'b0) || (ssrc_r == cfg_ssrc_r);
    assign hdr_ok_s        = (hdr0_r.version == RTP_VERSION) && !hdr0_r.padding &&
                             !hdr0_r.extension && (hdr0_r.csrc_count == 4'd0) &&
                             (hdr0_r.payload_type == PAYLOAD_TYPE) &&
                             !pd_s.continuation && ssrc_ok_s;
    assign pop_s           = popcount4(s_axis_tkeep);
    // Bit 16 is the borrow: more bytes arrived than the length counter still allowed.
    assign len_diff_s      = {1'b0, len_cnt_r} - {14'd0, pop_s};

    // Input ready: the output stage is the only storage, so stall only while payload is blocked.
    always_comb begin
        if (state_r == PAYLOAD_RECV) begin
            s_axis_tready = !out_valid_r | m_axis_tready;
        end else begin
            s_axis_tready = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_r <= IDLE_RECV;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode and per-packet event strobes.
    always_comb begin
        state_next_s = state_r;
        drop_s       = 1'b0;
        hdr_pass_s   = 1'b0;
        zero_len_s   = 1'b0;
        pay_last_s   = 1'b0;
        case (state_r)
            IDLE_RECV: begin
                if (in_fire_s && s_axis_tlast) begin
                    drop_s       = 1'b1;
                    state_next_s = IDLE_RECV;
                end else if (in_fire_s) begin
                    state_next_s = HEADER_RECV;
                end else begin
                    state_next_s = IDLE_RECV;
                end
            end
            HEADER_RECV: begin
                if (in_fire_s && s_axis_tlast) begin
                    drop_s       = 1'b1;
                    state_next_s = IDLE_RECV;
                end else if (in_fire_s && (beat_r == 3'd2)) begin
                    state_next_s = PD_HEADER_RECV;
                end else begin
                    state_next_s = HEADER_RECV;
                end
            end
            PD_HEADER_RECV: begin
                if (!in_fire_s) begin
                    state_next_s = PD_HEADER_RECV;
                end else if (!last_hdr_beat_s) begin
                    drop_s       = s_axis_tlast;
                    state_next_s = s_axis_tlast ? IDLE_RECV : PD_HEADER_RECV;
                end else if (!hdr_ok_s) begin
                    drop_s       = 1'b1;
                    state_next_s = s_axis_tlast ? IDLE_RECV : DROP_RECV;
                end else if (!s_axis_tlast) begin
                    hdr_pass_s   = 1'b1;
                    state_next_s = PAYLOAD_RECV;
                end else if (pd_s.length == 16'd0) begin
                    // Header-only packet that declared no payload is a legal, empty packet.
                    hdr_pass_s   = 1'b1;
                    zero_len_s   = 1'b1;
                    state_next_s = IDLE_RECV;
                end else begin
                    drop_s       = 1'b1;
                    state_next_s = IDLE_RECV;
                end
            end
            PAYLOAD_RECV: begin
                if (in_fire_s && s_axis_tlast) begin
                    pay_last_s   = 1'b1;
                    state_next_s = IDLE_RECV;
                end else begin
                    state_next_s = PAYLOAD_RECV;
                end
            end
            DROP_RECV: begin
                if (in_fire_s && s_axis_tlast) begin
                    state_next_s = IDLE_RECV;
                end else begin
                    state_next_s = DROP_RECV;
                end
            end
            default: begin
                state_next_s = IDLE_RECV;
            end
        endcase
    end

    // Header beat index and header field capture.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            beat_r     <= 3'd0;
            hdr0_r     <= rtp_hdr_w0_t'(32'd0);
            ssrc_r     <= 32'd0;
            pd_hi_r    <= 32'd0;
            cfg_ssrc_r <= 32'd0;
        end else begin
            if (in_fire_s) begin
                beat_r <= (state_next_s == HEADER_RECV || state_next_s == PD_HEADER_RECV) ?
                          beat_r + 3'd1 : 3'd0;
            end else begin
                beat_r <= beat_r;
            end
            if (in_fire_s && state_r == IDLE_RECV) begin
                hdr0_r <= rtp_hdr_w0_t'(s_axis_tdata);
            end else begin
                hdr0_r <= hdr0_r;
            end
            if (in_fire_s && state_r == HEADER_RECV && beat_r == 3'd2) begin
                ssrc_r <= s_axis_tdata;
            end else begin
                ssrc_r <= ssrc_r;
            end
            if (in_fire_s && state_r == PD_HEADER_RECV && beat_r == 3'd3) begin
                pd_hi_r <= s_axis_tdata;
            end else begin
                pd_hi_r <= pd_hi_r;
            end
            if (state_r == IDLE_RECV) begin
                cfg_ssrc_r <= cfg_ssrc;
            end else begin
                cfg_ssrc_r <= cfg_ssrc_r;
            end
        end
    end

    // Output register stage, SOF flag and line sideband.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            out_data_r  <= 32'd0;
            out_keep_r  <= 4'd0;
            out_user_r  <= 1'b0;
            out_last_r  <= 1'b0;
            out_valid_r <= 1'b0;
            sof_r       <= 1'b1;
            line_r      <= 15'd0;
            offset_r    <= 15'd0;
            field_r     <= 1'b0;
        end else begin
            if (state_r == PAYLOAD_RECV && in_fire_s) begin
                out_data_r  <= s_axis_tdata;
                out_keep_r  <= s_axis_tkeep;
                out_user_r  <= sof_r;
                out_last_r  <= s_axis_tlast;
                out_valid_r <= 1'b1;
            end else if (m_axis_tready) begin
                out_valid_r <= 1'b0;
            end else begin
                out_valid_r <= out_valid_r;
            end
            // A marker on the packet just completed wins over clearing by its own first beat.
            if ((pay_last_s || zero_len_s) && hdr0_r.marker) begin
                sof_r <= 1'b1;
            end else if (state_r == PAYLOAD_RECV && in_fire_s) begin
                sof_r <= 1'b0;
            end else begin
                sof_r <= sof_r;
            end
            if (hdr_pass_s) begin
                line_r   <= pd_s.line_num;
                offset_r <= pd_s.offset;
                field_r  <= pd_s.field;
            end else begin
                line_r   <= line_r;
            end
        end
    end

    // Payload length down-counter, length error pulse and statistics.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            len_cnt_r    <= 16'd0;
            len_uf_r     <= 1'b0;
            len_err_r    <= 1'b0;
            pkt_count_r  <= 32'd0;
            drop_count_r <= 16'd0;
        end else begin
            len_err_r <= 1'b0;
            if (hdr_pass_s) begin
                len_cnt_r <= pd_s.length;
                len_uf_r  <= 1'b0;
            end else if (state_r == PAYLOAD_RECV && in_fire_s) begin
                len_cnt_r <= len_diff_s[15:0];
                len_uf_r  <= len_uf_r | len_diff_s[16];
                len_err_r <= s_axis_tlast &
                             ((len_diff_s[15:0] != 16'd0) | len_diff_s[16] | len_uf_r);
            end else begin
                len_cnt_r <= len_cnt_r;
            end
            if ((pay_last_s || zero_len_s) && pkt_count_r != 32'hFFFF_FFFF) begin
                pkt_count_r <= pkt_count_r + 32'd1;
            end else begin
                pkt_count_r <= pkt_count_r;
            end
            if (drop_s && drop_count_r != 16'hFFFF) begin
                drop_count_r <= drop_count_r + 16'd1;
            end else begin
                drop_count_r <= drop_count_r;
            end
        end
    end

    rtp_engine_rx_seq_check u_seq_check (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .chk           (hdr_pass_s),
        .ext_seq       ({pd_s.ext_seq_num, hdr0_r.sequence_nr}),
        .seq_err       (seq_err),
        .seq_err_count (seq_err_count)
    );

    assign m_axis_tdata  = out_data_r;
    assign m_axis_tkeep  = out_keep_r;
    assign m_axis_tuser  = out_user_r;
    assign m_axis_tlast  = out_last_r;
    assign m_axis_tvalid = out_valid_r;
    assign m_line_num    = line_r;
    assign m_offset      = offset_r;
    assign m_field       = field_r;
    assign len_err       = len_err_r;
    assign pkt_count     = pkt_count_r;
    assign drop_count    = drop_count_r;

endmodule

// File: tb/tb_rtp_engine_rx.sv
// Directed testbench for rtp_engine_rx: builds RTP packets beat by beat,
// records every output transfer, and compares against hand-computed beats,
// counters and sideband values.
module tb_rtp_engine_rx;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [31:0] cfg_ssrc = 32'hCAFE_0001;
    logic [31:0] s_axis_tdata = 32'd0;
    logic [3:0]  s_axis_tkeep = 4'd0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic        s_axis_tlast = 1'b0;
    logic [31:0] m_axis_tdata;
    logic [3:0]  m_axis_tkeep;
    logic        m_axis_tuser, m_axis_tlast, m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic [14:0] m_line_num, m_offset;
    logic        m_field, seq_err, len_err;
    logic [31:0] pkt_count;
    logic [15:0] drop_count, seq_err_count;

    rtp_engine_rx dut (
        .aclk(aclk), .aresetn(aresetn), .cfg_ssrc(cfg_ssrc),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tlast(s_axis_tlast),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_line_num(m_line_num), .m_offset(m_offset), .m_field(m_field),
        .seq_err(seq_err), .len_err(len_err), .pkt_count(pkt_count),
        .drop_count(drop_count), .seq_err_count(seq_err_count)
    );

    always #5 aclk = ~aclk;

    int n_tests = 0;
    int n_fail = 0;
    int seq_pulses = 0;
    int len_pulses = 0;
    int exp_pkt = 0, exp_drop = 0, exp_seqc = 0, exp_lenp = 0;
    int rdy_mode = 0;          // 0: always ready, 1: random, 2: never ready
    bit hold_chk_en = 1'b1;
    bit sof_m = 1'b1;
    logic [35:0] in_q[$];      // {keep, data}
    logic [37:0] exp_q[$];     // {user, last, keep, data}
    logic [37:0] got_q[$];
    logic [37:0] prev_out = 38'd0;
    bit prev_stall = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Output ready generator.
    always @(negedge aclk) begin
        if (rdy_mode == 1) m_axis_tready = 1'($urandom_range(0, 1));
        else m_axis_tready = (rdy_mode == 0);
    end

    // Output monitor: records transfers, checks hold while stalled, counts pulses.
    always @(negedge aclk) begin
        logic [37:0] cur;
        #1;
        cur = {m_axis_tuser, m_axis_tlast, m_axis_tkeep, m_axis_tdata};
        if (prev_stall && hold_chk_en) check("stall_hold", {m_axis_tvalid, cur}, {1'b1, prev_out});
        if (m_axis_tvalid && m_axis_tready) got_q.push_back(cur);
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev_out = cur;
        if (seq_err) seq_pulses++;
        if (len_err) len_pulses++;
    end

    task automatic send_beat(input logic [35:0] b, input logic last);
        int guard;
        bit acc;
        guard = 0;
        acc = 1'b0;
        while (!acc) begin
            @(negedge aclk);
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = b[31:0];
            s_axis_tkeep  = b[35:32];
            s_axis_tlast  = last;
            #1;
            acc = s_axis_tready;
            guard++;
            if (!acc && guard > 2000) begin
                n_tests++;
                n_fail++;
                $display("FAIL send_timeout: observed tready=0 for %0d cycles, required 1", guard);
                $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
                $fatal(1, "input handshake stuck");
            end
        end
    endtask

    task automatic send_pkt();
        for (int i = 0; i < in_q.size(); i++) send_beat(in_q[i], i == in_q.size() - 1);
        in_q.delete();
    endtask

    task automatic settle();
        @(negedge aclk);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        repeat (4) @(negedge aclk);
    endtask

    task automatic build(input logic [1:0] ver, input logic [6:0] pt, input logic mk,
                         input logic [31:0] ext, input logic [15:0] len, input logic fld,
                         input logic [14:0] line, input logic [14:0] off, input int nhdr,
                         input int npay, input logic [3:0] lkeep, input logic [31:0] base,
                         input bit acc);
        logic [31:0] hdr [5];
        logic [31:0] d;
        logic [3:0]  k;
        hdr[0] = {ver, 2'b00, 4'd0, mk, pt, ext[15:0]};
        hdr[1] = 32'h1234_5678;
        hdr[2] = 32'hCAFE_0001;
        hdr[3] = {ext[31:16], len};
        hdr[4] = {fld, line, 1'b0, off};
        for (int i = 0; i < nhdr; i++) in_q.push_back({4'hF, hdr[i]});
        for (int i = 0; i < npay; i++) begin
            d = (base != 32'd0) ? base + 32'(i) * 32'h1010_1010 : $urandom;
            k = (i == npay - 1) ? lkeep : 4'hF;
            in_q.push_back({k, d});
            if (acc) exp_q.push_back({(i == 0) ? sof_m : 1'b0, (i == npay - 1), k, d});
        end
        if (acc && npay > 0) sof_m = 1'b0;
        if (acc && mk) sof_m = 1'b1;
    endtask

    task automatic drain(input string tag);
        int guard;
        guard = 0;
        while (got_q.size() < exp_q.size() && guard < 5000) begin
            @(negedge aclk);
            guard++;
        end
        repeat (4) @(negedge aclk);
        check({tag, "_beats"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) check(tag, got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_pkt"}, pkt_count, exp_pkt);
        check({tag, "_drop"}, drop_count, exp_drop);
        check({tag, "_seqc"}, seq_err_count, exp_seqc);
        check({tag, "_seqp"}, seq_pulses, exp_seqc);
        check({tag, "_lenp"}, len_pulses, exp_lenp);
    endtask

    initial begin
        int np, kb;
        logic [3:0] lk;
        repeat (3) @(negedge aclk);
        check("rst_tready", s_axis_tready, 1'b1);
        check("rst_tvalid", m_axis_tvalid, 1'b0);
        check_counts("rst");
        aresetn = 1'b1;
        repeat (2) @(negedge aclk);

        // 1: basic valid packet
        build(2'd2, 7'd96, 1'b0, 32'h0000_0010, 16'd8, 1'b0, 15'd5, 15'd0, 5, 2, 4'hF, 32'hA1A2_A3A4, 1'b1);
        send_pkt();
        settle();
        check("t1_first_beat", exp_q[0], {1'b1, 1'b0, 4'hF, 32'hA1A2_A3A4});
        drain("t1_data");
        exp_pkt = 1;
        check_counts("t1");
        check("t1_line", m_line_num, 15'd5);
        check("t1_offset", m_offset, 15'd0);

        // 2: bad version, bad payload type, then a good packet
        build(2'd1, 7'd96, 1'b0, 32'h0000_0011, 16'd8, 1'b0, 15'd9, 15'd9, 5, 2, 4'hF, 32'd0, 1'b0);
        send_pkt();
        settle();
        exp_drop = 1;
        check_counts("t2_ver");
        build(2'd2, 7'd97, 1'b0, 32'h0000_0011, 16'd8, 1'b0, 15'd9, 15'd9, 5, 2, 4'hF, 32'd0, 1'b0);
        send_pkt();
        build(2'd2, 7'd96, 1'b0, 32'h0000_0011, 16'd4, 1'b1, 15'd6, 15'h40, 5, 1, 4'hF, 32'd0, 1'b1);
        send_pkt();
        settle();
        drain("t2_data");
        exp_drop = 2; exp_pkt = 2;
        check_counts("t2");
        check("t2_line", m_line_num, 15'd6);
        check("t2_offset", m_offset, 15'h40);
        check("t2_field", m_field, 1'b1);

        // 3: sequence wrap into the extended half, then a gap
        build(2'd2, 7'd96, 1'b0, 32'h0000_FFFF, 16'd4, 1'b0, 15'd1, 15'd0, 5, 1, 4'hF, 32'd0, 1'b1);
        send_pkt();
        build(2'd2, 7'd96, 1'b0, 32'h0001_0000, 16'd4, 1'b0, 15'd1, 15'd0, 5, 1, 4'hF, 32'd0, 1'b1);
        send_pkt();
        settle();
        exp_pkt = 4; exp_seqc = 1;    // 0xFFFF itself breaks from expected 0x12
        check_counts("t3_wrap");
        build(2'd2, 7'd96, 1'b0, 32'h0001_0003, 16'd4, 1'b0, 15'd1, 15'd0, 5, 1, 4'hF, 32'd0, 1'b1);
        send_pkt();
        settle();
        drain("t3_data");
        exp_pkt = 5; exp_seqc = 2;
        check_counts("t3_gap");

        // 4: length overrun, exact partial last beat, truncated header, empty packets
        build(2'd2, 7'd96, 1'b0, 32'h0001_0004, 16'd8, 1'b0, 15'd2, 15'd0, 5, 3, 4'hF, 32'd0, 1'b1);
        send_pkt();
        settle();
        exp_pkt = 6; exp_lenp = 1;
        check_counts("t4_over");
        build(2'd2, 7'd96, 1'b0, 32'h0001_0005, 16'd6, 1'b0, 15'd2, 15'd0, 5, 2, 4'b1100, 32'd0, 1'b1);
        send_pkt();
        build(2'd2, 7'd96, 1'b0, 32'h0001_0006, 16'd8, 1'b0, 15'd2, 15'd0, 3, 0, 4'hF, 32'd0, 1'b0);
        send_pkt();
        build(2'd2, 7'd96, 1'b0, 32'h0001_0006, 16'd0, 1'b0, 15'd2, 15'd0, 5, 0, 4'hF, 32'd0, 1'b1);
        send_pkt();
        build(2'd2, 7'd96, 1'b0, 32'h0001_0007, 16'd4, 1'b0, 15'd2, 15'd0, 5, 0, 4'hF, 32'd0, 1'b0);
        send_pkt();
        settle();
        drain("t4_data");
        exp_pkt = 8; exp_drop = 4;
        check_counts("t4");

        // 6a: marker on packet k gives SOF on packet k+1 only
        build(2'd2, 7'd96, 1'b1, 32'h0001_0007, 16'd4, 1'b0, 15'd3, 15'd0, 5, 1, 4'hF, 32'd0, 1'b1);
        send_pkt();
        build(2'd2, 7'd96, 1'b0, 32'h0001_0008, 16'd8, 1'b0, 15'd0, 15'd0, 5, 2, 4'hF, 32'd0, 1'b1);
        send_pkt();
        build(2'd2, 7'd96, 1'b0, 32'h0001_0009, 16'd4, 1'b0, 15'd1, 15'd0, 5, 1, 4'hF, 32'd0, 1'b1);
        send_pkt();
        settle();
        check("t6_sof_k", exp_q[0][37], 1'b0);
        check("t6_sof_k1", exp_q[1][37], 1'b1);
        drain("t6_data");
        exp_pkt = 11;
        check_counts("t6");

        // 5: 100 back-to-back packets under random backpressure
        rdy_mode = 1;
        for (int p = 0; p < 100; p++) begin
            np = $urandom_range(1, 4);
            kb = $urandom_range(1, 4);
            lk = 4'(4'hF << (4 - kb));
            build(2'd2, 7'd96, 1'b0, 32'h0001_000A + 32'(p), 16'(4 * (np - 1) + kb), 1'b0,
                  15'(p), 15'd0, 5, np, lk, 32'd0, 1'b1);
            send_pkt();
        end
        settle();
        drain("t5_data");
        exp_pkt = 111;
        check_counts("t5");

        // 6b: asynchronous reset while a payload beat is stalled on the output
        rdy_mode = 2;
        build(2'd2, 7'd96, 1'b0, 32'h0001_006E, 16'd12, 1'b0, 15'd7, 15'd3, 5, 3, 4'hF, 32'd0, 1'b0);
        for (int i = 0; i < 6; i++) send_beat(in_q[i], 1'b0);
        in_q.delete();
        @(negedge aclk);
        s_axis_tvalid = 1'b0;
        repeat (2) @(negedge aclk);
        check("t6_pre_valid", m_axis_tvalid, 1'b1);
        check("t6_pre_tready", s_axis_tready, 1'b0);
        hold_chk_en = 1'b0;
        #2 aresetn = 1'b0;
        #1;
        check("t6_rst_valid", m_axis_tvalid, 1'b0);
        check("t6_rst_out", {m_axis_tuser, m_axis_tlast, m_axis_tkeep, m_axis_tdata}, 38'd0);
        check("t6_rst_tready", s_axis_tready, 1'b1);
        check("t6_rst_line", {m_line_num, m_offset, m_field}, 31'd0);
        check("t6_rst_cnt", {pkt_count, drop_count, seq_err_count}, 64'd0);
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        rdy_mode = 0;
        repeat (2) @(negedge aclk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
